// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointers and count carry one extra bit so that full and empty can be told apart.
    function automatic int cnt_width(input int asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DSIZE storage for sync_fifo_flags: one synchronous write port and one asynchronous read port.
module fifo_ram #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags, FWFT or registered read, and flush.
// Defining SYNC_FIFO_ERR_FLAGS_EN enables the sticky overflow/underflow flags; otherwise both are tied to 0.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DSIZE         = 8,
    parameter int ASIZE         = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = FIFO_MODE_FWFT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DSIZE-1:0]             wdata,
    input  logic                         winc,
    input  logic                         rinc,
    input  logic                         flush,
    output logic [DSIZE-1:0]             rdata,
    output logic                         wfull,
    output logic                         rempty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [cnt_width(ASIZE)-1:0]  count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int CW    = cnt_width(ASIZE);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [CW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic [DSIZE-1:0] ram_rdata;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok, rd_ok;

    fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr_q[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[ASIZE-1:0]),
        .rdata (ram_rdata)
    );

    // Flags decode the count register, so they trail the accepted access by one cycle.
    assign wfull        = (count_q == DEPTH_C);
    assign rempty       = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign rdata        = (FWFT == FIFO_MODE_FWFT) ? ram_rdata : rdata_q;

    always_comb begin
        wr_ok   = winc && !wfull && !flush;
        rd_ok   = rinc && !rempty && !flush;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = rdata_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - 1'b1;
            end
        end

        // In registered mode rdata only moves on an accepted read, so it survives flush.
        if ((FWFT == FIFO_MODE_REG) && rd_ok) begin
            rdata_d = ram_rdata;
        end
    end

    always_comb begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        overflow_d  = !flush && (overflow_q  || (winc && wfull));
        underflow_d = !flush && (underflow_q || (rinc && rempty));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: an FWFT instance and a registered-read instance share one stimulus stream.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wdata;
    logic       winc, rinc, flush;

    logic [7:0] f_rdata, r_rdata;
    logic       f_wfull, f_rempty, f_af, f_ae, f_ovf, f_unf;
    logic       r_wfull, r_rempty, r_af, r_ae, r_ovf, r_unf;
    logic [3:0] f_count, r_count;

    int checks = 0;
    int errors = 0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .flush(flush),
        .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .flush(flush),
        .rdata(r_rdata), .wfull(r_wfull), .rempty(r_rempty), .almost_full(r_af),
        .almost_empty(r_ae), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic ovf, input logic unf);
        chk({tag, "_cnt_f"}, 32'(f_count), 32'(cnt));
        chk({tag, "_cnt_r"}, 32'(r_count), 32'(cnt));
        chk({tag, "_full"}, 32'(f_wfull), 32'(cnt == 8));
        chk({tag, "_empty"}, 32'(f_rempty), 32'(cnt == 0));
        chk({tag, "_af"}, 32'(f_af), 32'(cnt >= 6));
        chk({tag, "_ae"}, 32'(f_ae), 32'(cnt <= 1));
        chk({tag, "_ovf"}, 32'(f_ovf), 32'(ovf));
        chk({tag, "_unf"}, 32'(r_unf), 32'(unf));
    endtask

    initial begin
        rst_n = 1'b0;
        wdata = 8'h00;
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
        #12 rst_n = 1'b1;
        cyc();

        // Reset state
        chk_state("reset", 0, 1'b0, 1'b0);
        chk("reset_rdata_r", 32'(r_rdata), 32'h0);

        // 1: fill with 0x11..0x18, then one rejected write
        for (int i = 0; i < 8; i++) begin
            winc  = 1'b1;
            wdata = 8'(8'h11 + i);
            cyc();
            chk_state($sformatf("fill%0d", i), i + 1, 1'b0, 1'b0);
        end
        wdata = 8'hFF;
        cyc();
        winc = 1'b0;
        chk_state("wr9", 8, ERR_ON, 1'b0);
        chk("head_f", 32'(f_rdata), 32'h11);

        // 2: continuous read; FWFT shows next head, registered shows word just read
        for (int i = 0; i < 8; i++) begin
            rinc = 1'b1;
            cyc();
            chk($sformatf("drain%0d_cnt", i), 32'(f_count), 32'(7 - i));
            chk($sformatf("drain%0d_rd_r", i), 32'(r_rdata), 32'(8'h11 + i));
            if (i < 7) chk($sformatf("drain%0d_rd_f", i), 32'(f_rdata), 32'(8'h12 + i));
        end
        chk("drained_empty", 32'(f_rempty), 32'h1);
        cyc();
        rinc = 1'b0;
        chk_state("rd9", 0, ERR_ON, ERR_ON);
        chk("rd9_rd_r_hold", 32'(r_rdata), 32'h18);

        // 3: registered-read latency
        winc  = 1'b1;
        wdata = 8'hA5;
        cyc();
        winc = 1'b0;
        chk("a5_cnt", 32'(r_count), 32'h1);
        chk("a5_fwft", 32'(f_rdata), 32'hA5);
        rinc = 1'b1;
        chk("a5_before", 32'(r_rdata), 32'h18);
        cyc();
        rinc = 1'b0;
        chk("a5_after", 32'(r_rdata), 32'hA5);
        chk("a5_cnt0", 32'(r_count), 32'h0);
        cyc();
        chk("a5_hold", 32'(r_rdata), 32'hA5);

        // 4: four words resident, 20 cycles of simultaneous read/write across pointer wrap
        for (int i = 0; i < 4; i++) begin
            winc  = 1'b1;
            wdata = 8'(8'h30 + i);
            cyc();
        end
        chk("stream_cnt0", 32'(f_count), 32'h4);
        rinc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wdata = 8'(8'h34 + i);
            chk($sformatf("stream%0d_f", i), 32'(f_rdata), 32'(8'h30 + i));
            cyc();
            chk($sformatf("stream%0d_cnt", i), 32'(f_count), 32'h4);
            chk($sformatf("stream%0d_r", i), 32'(r_rdata), 32'(8'h30 + i));
        end
        rinc = 1'b0;

        // 5: full with simultaneous access, then empty with simultaneous access
        for (int i = 0; i < 4; i++) begin
            wdata = 8'(8'h48 + i);
            cyc();
        end
        winc = 1'b0;
        chk_state("full5", 8, ERR_ON, ERR_ON);
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'hEE;
        cyc();
        winc = 1'b0;
        chk("full_rw_cnt", 32'(f_count), 32'h7);
        chk("full_rw_rd_r", 32'(r_rdata), 32'h44);
        chk("full_rw_head", 32'(f_rdata), 32'h45);
        for (int i = 0; i < 7; i++) cyc();
        rinc = 1'b0;
        chk("drain5_cnt", 32'(f_count), 32'h0);
        chk("drain5_last", 32'(r_rdata), 32'h4B);
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'h77;
        cyc();
        rinc = 1'b0;
        chk("empty_rw_cnt", 32'(r_count), 32'h1);
        chk("empty_rw_f", 32'(f_rdata), 32'h77);
        chk("empty_rw_r_hold", 32'(r_rdata), 32'h4B);

        // 6: flush beats winc/rinc, then asynchronous reset mid-write
        for (int i = 0; i < 4; i++) begin
            wdata = 8'(8'h78 + i);
            cyc();
        end
        chk_state("pre_flush", 5, ERR_ON, ERR_ON);
        rinc  = 1'b1;
        flush = 1'b1;
        wdata = 8'hCC;
        cyc();
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
        chk_state("flush", 0, 1'b0, 1'b0);
        chk("flush_r_hold", 32'(r_rdata), 32'h4B);
        cyc();
        chk("post_flush_cnt", 32'(f_count), 32'h0);
        winc  = 1'b1;
        wdata = 8'h99;
        cyc();
        chk("after_flush_f", 32'(f_rdata), 32'h99);
        chk("after_flush_cnt", 32'(f_count), 32'h1);
        rinc = 1'b1;
        cyc();
        chk("pre_rst_r", 32'(r_rdata), 32'h99);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 1'b0, 1'b0);
        chk("async_rst_r", 32'(r_rdata), 32'h0);
        winc = 1'b0;
        rinc = 1'b0;
        #3 rst_n = 1'b1;
        cyc();
        chk("rst_release_cnt", 32'(f_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO; next-generation successor to the team's dual-clock gray-pointer FIFO.
- Used wherever producer and consumer share a clock, so there are no synchronisers.
- Adds the following over the dual-clock FIFO: occupancy count, programmable almost-full and almost-empty flags, selectable first-word-fall-through (FWFT) or registered-read mode, and synchronous flush.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 3, address width; DEPTH = 1 << ASIZE.
- AFULL_THRESH, 6, almost_full asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 1, almost_empty asserts when count <= this value; legal range 0..DEPTH-1.
- FWFT, 1, read mode: 1 = head word visible combinationally on rdata; 0 = rdata registered, one cycle after the read is accepted.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wdata  in  DSIZE  write data.
- winc  in  1  write request.
- rinc  in  1  read request.
- flush  in  1  synchronous clear.
- rdata  out  DSIZE  read data.
- wfull  out  1  FIFO full.
- rempty  out  1  FIFO empty.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; see Optional Feature.
- underflow  out  1  sticky; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Pointers = 0 and count = 0.
  - rempty = 1, wfull = 0.
  - almost_empty = 1, almost_full = 0.
  - rdata = 0 when FWFT=0.
  - overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Pointers: wptr and rptr are ASIZE+1 bits, binary. The memory is indexed by the low ASIZE bits. The MSB distinguishes full from empty, and pointers wrap naturally at 2*DEPTH.
- Write acceptance: wr_ok = winc && !wfull && !flush. On wr_ok: mem[wptr] <= wdata; wptr += 1.
- Read acceptance: rd_ok = rinc && !rempty && !flush. On rd_ok: rptr += 1.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both occur in the same cycle.
- Count never exceeds DEPTH and never goes below 0.
- Flags are combinational decodes of the count register:
  - wfull = (count == DEPTH).
  - rempty = (count == 0).
  - Flags therefore update the cycle after the accepted access.
- Simultaneous read and write:
  - When full: only the read is accepted (wfull blocks the write).
  - When empty: only the write is accepted. In FWFT=1 mode the new word appears on rdata the next cycle.
- FWFT=1 read path: rdata = mem[rptr[ASIZE-1:0]], combinational. Valid whenever rempty=0. Zero-latency read.
- FWFT=0 read path:
  - On rd_ok, rdata <= mem[rptr[ASIZE-1:0]]. One-cycle latency.
  - Otherwise rdata holds its value.
- Flush:
  - Synchronous. Next cycle: pointers = 0, count = 0, rempty = 1.
  - Flush has priority over winc and rinc in the same cycle; neither is accepted.
  - rdata holds its value in FWFT=0 mode.
- Reset mid-operation: asserting rst_n forces all reset values immediately, independent of clk.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined:
  - overflow sets on winc && wfull && !flush.
  - underflow sets on rinc && rempty && !flush.
  - Both are sticky until flush or reset.
  - A rejected access never modifies memory, pointers or count.
- When undefined: overflow and underflow are tied to 0. The port list is unchanged.

Decomposition:
- Package fifo_pkg holds the shared constants:
  - FIFO_MODE_REG = 0 and FIFO_MODE_FWFT = 1.
  - The count-width helper (ASIZE+1).
- One sub-module, fifo_ram:
  - DEPTH x DSIZE.
  - One synchronous write port, one asynchronous read port.
  - sync_fifo_flags instantiates it and owns pointers, count, flags and the read register.

Test Plan (all at DSIZE=8, ASIZE=3):
1. Reset, then write 0x11..0x18 (8 words). Expected: count 1..8; almost_full rises after the 6th write; wfull=1 after the 8th. A 9th write of 0xFF is rejected, count stays 8, overflow=1 (with the macro).
2. FWFT=1, FIFO holding 0x11..0x18, continuous rinc. Expected: rdata shows 0x11 before the first read, then 0x12..0x18 on successive cycles. rempty=1 after the 8th read. A further rinc sets underflow=1.
3. FWFT=0, write 0xA5, then read. Expected: rdata=0xA5 exactly one cycle after the rinc cycle; rdata holds 0xA5 afterwards.
4. FIFO holding 4 words, winc and rinc together for 20 cycles with incrementing data. Expected: count stays 4; pointers wrap past 15 without error; data order preserved.
5. Full FIFO, winc+rinc together. Expected: read accepted, write rejected, count=7. Empty FIFO, winc+rinc together: write accepted, count=1.
6. FIFO holding 5 words with overflow set, assert flush together with winc and rinc. Expected: next cycle count=0, rempty=1, overflow=0, no data accepted. Then assert rst_n low mid-write: all outputs return to reset values asynchronously.
